// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared store encodings, drain/refill FSM states and size helper
//            for the L1 data-cache store buffer.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam logic [2:0] ST_SB = 3'b000;
    localparam logic [2:0] ST_SH = 3'b001;
    localparam logic [2:0] ST_SW = 3'b010;
    localparam logic [2:0] ST_SD = 3'b011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        REFILL = 2'd2
    } state_t;

    // Access width in bytes; zero marks an encoding that is not a store.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            ST_SB:   return 4'd1;
            ST_SH:   return 4'd2;
            ST_SW:   return 4'd4;
            ST_SD:   return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_store_align.sv
`default_nettype none
// ============================================================================
// Module   : cache_store_align
// Brief    : Places a LSB-justified store into its lanes of a cache line and
//            flags stores that are not naturally aligned.
// Revision : 1.0 - initial release
// ============================================================================
module cache_store_align
    import cache_pkg::*;
#(
    parameter  int BLOCK_BYTES = 16,
    localparam int OFFSET_W    = $clog2(BLOCK_BYTES),
    localparam int BLOCK_W     = 8 * BLOCK_BYTES
) (
    input  logic [2:0]             i_funct3,
    input  logic [OFFSET_W-1:0]    i_offset,
    input  logic [63:0]            i_data,
    output logic [BLOCK_W-1:0]     o_data,
    output logic [BLOCK_BYTES-1:0] o_byte_en,
    output logic                   o_misalign
);

    logic [7:0]  w_size_mask;
    logic [63:0] w_bytes;

    always_comb begin
        w_size_mask = 8'((16'h0001 << size_bytes(i_funct3)) - 16'h0001);
        w_bytes     = '0;
        for (int k = 0; k < 8; k++) begin
            if (w_size_mask[k]) begin
                w_bytes[8*k +: 8] = i_data[8*k +: 8];
            end
        end
        o_data    = BLOCK_W'(w_bytes) << {i_offset, 3'b000};
        o_byte_en = BLOCK_BYTES'(w_size_mask) << i_offset;

        o_misalign = 1'b1;
        case (i_funct3)
            ST_SB:   o_misalign = 1'b0;
            ST_SH:   o_misalign = i_offset[0];
            ST_SW:   o_misalign = |i_offset[1:0];
            ST_SD:   o_misalign = |i_offset[2:0];
            default: o_misalign = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cache_l1_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cache_l1_store_buffer
// Brief    : Aligning, line-merging store FIFO that drains into the L1 data
//            array, interleaved with full-line L2 refill writes.
// Revision : 1.0 - initial release
// ============================================================================
module cache_l1_store_buffer
    import cache_pkg::*;
#(
    parameter  int BLOCK_BYTES = 16,
    parameter  int ADDR_W      = 32,
    parameter  int DEPTH       = 4,
    localparam int OFFSET_W    = $clog2(BLOCK_BYTES),
    localparam int LINE_W      = ADDR_W - OFFSET_W,
    localparam int BLOCK_W     = 8 * BLOCK_BYTES,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   st_valid_i,
    output logic                   st_ready_o,
    input  logic [ADDR_W-1:0]      st_addr_i,
    input  logic [2:0]             st_funct3_i,
    input  logic [63:0]            st_data_i,
    output logic                   misalign_o,
    input  logic                   refill_valid_i,
    output logic                   refill_ready_o,
    input  logic [LINE_W-1:0]      refill_line_i,
    input  logic [BLOCK_W-1:0]     refill_data_i,
    output logic                   wr_valid_o,
    input  logic                   wr_ready_i,
    output logic [LINE_W-1:0]      wr_line_o,
    output logic [BLOCK_W-1:0]     wr_data_o,
    output logic [BLOCK_BYTES-1:0] wr_byte_en_o,
    output logic                   wr_refill_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   empty_o
);

    logic [DEPTH-1:0]       r_valid;
    logic [LINE_W-1:0]      r_line [DEPTH];
    logic [BLOCK_W-1:0]     r_data [DEPTH];
    logic [BLOCK_BYTES-1:0] r_be   [DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;
    state_t                 r_state;
    logic                   r_wr_valid;
    logic                   r_wr_refill;
    logic                   r_refill_ready;
    logic                   r_misalign;
    logic [LINE_W-1:0]      r_ref_line;
    logic [BLOCK_W-1:0]     r_ref_data;

    logic [BLOCK_W-1:0]     w_st_data;
    logic [BLOCK_BYTES-1:0] w_st_be;
    logic [BLOCK_W-1:0]     w_bit_mask;
    logic                   w_misal;
    logic [LINE_W-1:0]      w_st_line;
    logic [PTR_W-1:0]       w_young;
    logic                   w_merge_hit;
    logic                   w_accept;
    logic                   w_merge;
    logic                   w_alloc;
    logic                   w_pop;
    logic                   w_refill_take;

    cache_store_align #(
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_align (
        .i_funct3   (st_funct3_i),
        .i_offset   (st_addr_i[OFFSET_W-1:0]),
        .i_data     (st_data_i),
        .o_data     (w_st_data),
        .o_byte_en  (w_st_be),
        .o_misalign (w_misal)
    );

    always_comb begin
        w_bit_mask = '0;
        for (int b = 0; b < BLOCK_BYTES; b++) begin
            w_bit_mask[8*b +: 8] = {8{w_st_be[b]}};
        end
    end

    assign w_st_line = st_addr_i[ADDR_W-1:OFFSET_W];
    assign w_young   = r_tail - PTR_W'(1);
    // The head entry under an active drain is frozen so the write port stays stable.
    assign w_merge_hit = r_valid[w_young] && (r_line[w_young] == w_st_line) &&
                         !((r_state == DRAIN) && (w_young == r_head));

    assign st_ready_o    = (r_count < CNT_W'(DEPTH)) || w_merge_hit;
    assign w_accept      = st_valid_i && st_ready_o;
    assign w_merge       = w_accept && !w_misal && w_merge_hit;
    assign w_alloc       = w_accept && !w_misal && !w_merge_hit;
    assign w_pop         = (r_state == DRAIN) && wr_ready_i;
    assign w_refill_take = (r_state == IDLE) && r_refill_ready && refill_valid_i;

    // Entry payloads carry no reset; occupancy is tracked by r_valid/r_count.
    always_ff @(posedge clk_i) begin
        if (w_merge) begin
            r_data[w_young] <= (r_data[w_young] & ~w_bit_mask) | w_st_data;
            r_be[w_young]   <= r_be[w_young] | w_st_be;
        end else if (w_alloc) begin
            r_line[r_tail] <= w_st_line;
            r_data[r_tail] <= w_st_data;
            r_be[r_tail]   <= w_st_be;
        end
        if (w_refill_take) begin
            r_ref_line <= refill_line_i;
            r_ref_data <= refill_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid        <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_state        <= IDLE;
            r_wr_valid     <= 1'b0;
            r_wr_refill    <= 1'b0;
            r_refill_ready <= 1'b0;
            r_misalign     <= 1'b0;
        end else begin
            r_misalign <= w_accept && w_misal;

            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end

            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                IDLE: begin
                    if (w_refill_take) begin
                        r_state        <= REFILL;
                        r_wr_valid     <= 1'b1;
                        r_wr_refill    <= 1'b1;
                        r_refill_ready <= 1'b0;
                    end else if (r_count != '0) begin
                        r_state        <= DRAIN;
                        r_wr_valid     <= 1'b1;
                        r_wr_refill    <= 1'b0;
                        r_refill_ready <= 1'b0;
                    end else begin
                        r_refill_ready <= 1'b1;
                    end
                end
                DRAIN, REFILL: begin
                    if (wr_ready_i) begin
                        r_state        <= IDLE;
                        r_wr_valid     <= 1'b0;
                        r_wr_refill    <= 1'b0;
                        r_refill_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_wr_valid     <= 1'b0;
                    r_wr_refill    <= 1'b0;
                    r_refill_ready <= 1'b0;
                end
            endcase
        end
    end

    assign wr_valid_o     = r_wr_valid;
    assign wr_refill_o    = r_wr_refill;
    assign wr_line_o      = r_wr_refill ? r_ref_line : r_line[r_head];
    assign wr_data_o      = r_wr_refill ? r_ref_data : r_data[r_head];
    assign wr_byte_en_o   = r_wr_refill ? {BLOCK_BYTES{1'b1}} : r_be[r_head];
    assign refill_ready_o = r_refill_ready;
    assign misalign_o     = r_misalign;
    assign count_o        = r_count;
    assign empty_o        = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_cache_l1_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_l1_store_buffer
// Brief    : Directed scenarios plus random traffic against a queue-based
//            reference model of the store buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_l1_store_buffer;
    import cache_pkg::*;

    localparam int BB    = 16;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int OW    = 4;
    localparam int LW    = AW - OW;
    localparam int BW    = 8 * BB;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          st_valid_i;
    logic          st_ready_o;
    logic [AW-1:0] st_addr_i;
    logic [2:0]    st_funct3_i;
    logic [63:0]   st_data_i;
    logic          misalign_o;
    logic          refill_valid_i;
    logic          refill_ready_o;
    logic [LW-1:0] refill_line_i;
    logic [BW-1:0] refill_data_i;
    logic          wr_valid_o;
    logic          wr_ready_i;
    logic [LW-1:0] wr_line_o;
    logic [BW-1:0] wr_data_o;
    logic [BB-1:0] wr_byte_en_o;
    logic          wr_refill_o;
    logic [2:0]    count_o;
    logic          empty_o;

    always #5 clk_i = ~clk_i;

    cache_l1_store_buffer #(
        .BLOCK_BYTES (BB),
        .ADDR_W      (AW),
        .DEPTH       (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .st_valid_i     (st_valid_i),
        .st_ready_o     (st_ready_o),
        .st_addr_i      (st_addr_i),
        .st_funct3_i    (st_funct3_i),
        .st_data_i      (st_data_i),
        .misalign_o     (misalign_o),
        .refill_valid_i (refill_valid_i),
        .refill_ready_o (refill_ready_o),
        .refill_line_i  (refill_line_i),
        .refill_data_i  (refill_data_i),
        .wr_valid_o     (wr_valid_o),
        .wr_ready_i     (wr_ready_i),
        .wr_line_o      (wr_line_o),
        .wr_data_o      (wr_data_o),
        .wr_byte_en_o   (wr_byte_en_o),
        .wr_refill_o    (wr_refill_o),
        .count_o        (count_o),
        .empty_o        (empty_o)
    );

    typedef struct {
        logic [LW-1:0] line;
        logic [BW-1:0] data;
        logic [BB-1:0] be;
    } ent_t;

    // Reference model: pending stores oldest-first, plus the write-port phase
    // (0 idle, 1 draining the oldest store, 2 writing a refill).
    ent_t          q[$];
    int            m_phase;
    bit            m_rr;
    bit            m_mis;
    logic [LW-1:0] m_rline;
    logic [BW-1:0] m_rdata;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input logic [AW-1:0] a);
        if (q.size() == 0) return 1'b0;
        if (q[q.size()-1].line != a[AW-1:OW]) return 1'b0;
        return !(m_phase == 1 && q.size() == 1);
    endfunction

    task automatic m_reset();
        q.delete();
        m_phase = 0;
        m_rr    = 1'b0;
        m_mis   = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit stv, input logic [AW-1:0] a, input logic [2:0] f3,
                        input logic [63:0] d, input bit rfv, input logic [LW-1:0] rl,
                        input logic [BW-1:0] rd, input bit wrr, input bit rst);
        bit            exp_ready, acc, bad, pop, nrr;
        int            lane, sz, nphase;
        ent_t          e;
        logic [BW-1:0] sd;
        logic [BB-1:0] sbe;
        @(negedge clk_i);
        st_valid_i     = stv;
        st_addr_i      = a;
        st_funct3_i    = f3;
        st_data_i      = d;
        refill_valid_i = rfv;
        refill_line_i  = rl;
        refill_data_i  = rd;
        wr_ready_i     = wrr;
        rst_i          = rst;
        #1;
        exp_ready = (q.size() < DEPTH) || m_hit(a);
        check("st_ready", st_ready_o, exp_ready);
        check("count", count_o, q.size());
        check("empty", empty_o, q.size() == 0);
        check("misalign", misalign_o, m_mis);
        check("refill_ready", refill_ready_o, m_rr);
        check("wr_valid", wr_valid_o, m_phase != 0);
        if (m_phase == 2) begin
            check("wr_refill", wr_refill_o, 1'b1);
            check("wr_line_refill", wr_line_o, m_rline);
            check("wr_data_refill", wr_data_o, m_rdata);
            check("wr_be_refill", wr_byte_en_o, {BB{1'b1}});
        end else if (m_phase == 1) begin
            check("wr_refill", wr_refill_o, 1'b0);
            check("wr_line", wr_line_o, q[0].line);
            check("wr_data", wr_data_o, q[0].data);
            check("wr_be", wr_byte_en_o, q[0].be);
        end
        if (rst) begin
            m_reset();
            return;
        end

        nphase = m_phase;
        nrr    = m_rr;
        if (m_phase == 0) begin
            if (m_rr && rfv) begin
                nphase  = 2;
                nrr     = 1'b0;
                m_rline = rl;
                m_rdata = rd;
            end else if (q.size() != 0) begin
                nphase = 1;
                nrr    = 1'b0;
            end else begin
                nrr = 1'b1;
            end
        end else if (wrr) begin
            nphase = 0;
            nrr    = 1'b1;
        end
        pop = (m_phase == 1) && wrr;

        acc  = stv && exp_ready;
        lane = int'(a[OW-1:0]);
        sz   = (f3 <= 3'd3) ? (1 << f3) : 0;
        bad  = (sz == 0) || (lane % sz != 0);
        m_mis = acc && bad;
        if (acc && !bad) begin
            sd  = '0;
            sbe = '0;
            for (int k = 0; k < sz; k++) begin
                sd[8*(lane+k) +: 8] = d[8*k +: 8];
                sbe[lane+k]         = 1'b1;
            end
            if (m_hit(a)) begin
                e = q.pop_back();
                for (int b = 0; b < BB; b++) begin
                    if (sbe[b]) e.data[8*b +: 8] = sd[8*b +: 8];
                end
                e.be = e.be | sbe;
                q.push_back(e);
            end else begin
                e.line = a[AW-1:OW];
                e.data = sd;
                e.be   = sbe;
                q.push_back(e);
            end
        end
        if (pop) void'(q.pop_front());
        m_phase = nphase;
        m_rr    = nrr;
    endtask

    task automatic idle(input int n, input bit wrr);
        for (int i = 0; i < n; i++) step(1'b0, '0, 3'd0, '0, 1'b0, '0, '0, wrr, 1'b0);
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [2:0] f3, input logic [63:0] d, input bit wrr);
        step(1'b1, a, f3, d, 1'b0, '0, '0, wrr, 1'b0);
    endtask

    logic [BW-1:0] ref_pat;

    initial begin
        int            lane;
        logic [2:0]    f3;
        logic [AW-1:0] a;

        rst_i = 1'b1; st_valid_i = 1'b0; st_addr_i = '0; st_funct3_i = '0; st_data_i = '0;
        refill_valid_i = 1'b0; refill_line_i = '0; refill_data_i = '0; wr_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1'b1);
        check("rst_wr_valid", wr_valid_o, 1'b0);
        check("rst_refill_ready", refill_ready_o, 1'b0);
        m_reset();

        // Single byte store lands in lane 7 two cycles after acceptance.
        store(32'h0000_0007, ST_SB, 64'hAB, 1'b0);
        idle(1, 1'b0);
        @(posedge clk_i); #1;
        check("sb_valid", wr_valid_o, 1'b1);
        check("sb_be", wr_byte_en_o, 16'h0080);
        check("sb_data", wr_data_o, 128'h0000_0000_0000_0000_AB00_0000_0000_0000);
        idle(3, 1'b1);

        // Back-to-back SH then SW to one line merge into one entry.
        store(32'h0000_001E, ST_SH, 64'h1234, 1'b0);
        store(32'h0000_0018, ST_SW, 64'hDEAD_BEEF, 1'b0);
        idle(1, 1'b0);
        @(posedge clk_i); #1;
        check("merge_count", count_o, 1);
        check("merge_be", wr_byte_en_o, 16'hCF00);
        check("merge_data", wr_data_o, 128'h1234_0000_DEAD_BEEF_0000_0000_0000_0000);
        idle(3, 1'b1);

        // Misaligned word: accepted, not buffered, flagged next cycle.
        store(32'h0000_0022, ST_SW, 64'h55, 1'b1);
        check("misal_ready", st_ready_o, 1'b1);
        @(posedge clk_i); #1;
        check("misal_flag", misalign_o, 1'b1);
        check("misal_count", count_o, 0);
        idle(3, 1'b1);

        // Fill all entries, then probe a new line and the youngest line.
        for (int i = 0; i < 4; i++) store(32'h0000_0100 + 32'(i * 16), ST_SW, 64'(32'h1000 + i), 1'b0);
        store(32'h0000_0140, ST_SW, 64'h77, 1'b0);
        check("full_new_line_ready", st_ready_o, 1'b0);
        store(32'h0000_0134, ST_SB, 64'h99, 1'b0);
        check("full_young_line_ready", st_ready_o, 1'b1);
        idle(12, 1'b1);

        // Refill beats a pending store; a refill during a stalled drain waits.
        ref_pat = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
        store(32'h0000_0200, ST_SW, 64'h11, 1'b0);
        step(1'b1 ^ 1'b1, '0, 3'd0, '0, 1'b1, 28'h0000777, ref_pat, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        check("refill_first", wr_refill_o, 1'b1);
        check("refill_be", wr_byte_en_o, 16'hFFFF);
        idle(4, 1'b1);
        store(32'h0000_0300, ST_SD, 64'h0123_4567_89AB_CDEF, 1'b0);
        idle(1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 3'd0, '0, 1'b1, 28'h0000888, ~ref_pat, 1'b0, 1'b0);
        step(1'b0, '0, 3'd0, '0, 1'b1, 28'h0000888, ~ref_pat, 1'b1, 1'b0);
        step(1'b0, '0, 3'd0, '0, 1'b1, 28'h0000888, ~ref_pat, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Reset with three entries buffered and the drain stalled.
        for (int i = 0; i < 3; i++) store(32'h0000_0400 + 32'(i * 16), ST_SB, 64'(i + 1), 1'b0);
        idle(1, 1'b0);
        step(1'b0, '0, 3'd0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        @(posedge clk_i); #1;
        check("rst_mid_wr_valid", wr_valid_o, 1'b0);
        check("rst_mid_count", count_o, 0);
        check("rst_mid_empty", empty_o, 1'b1);
        idle(4, 1'b1);

        // Random traffic over a handful of lines so merges and full buffers occur.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 4) != 0) begin
                f3   = 3'($urandom_range(0, 3));
                lane = $urandom_range(0, 15) & ~((1 << f3) - 1);
            end else begin
                f3   = 3'($urandom_range(0, 7));
                lane = $urandom_range(0, 15);
            end
            a = 32'h8000_0000 | (32'($urandom_range(0, 4)) << 4) | 32'(lane);
            step($urandom_range(0, 9) < 6, a, f3, {$urandom, $urandom},
                 $urandom_range(0, 9) < 1, LW'($urandom),
                 {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
